// File: rtl/trap_arbiter.sv
// Oldest-first exception arbiter: latches one trap record, holds it until the CSR unit
// acks it, and drops into a sticky lockup after too many back-to-back traps.
module trap_arbiter #(
    parameter int XLEN          = 32,
    parameter int NUM_SRC       = 4,
    parameter int MISALIGN_TRAP = 0,
    parameter int LOCKUP_LIMIT  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_SRC-1:0]      src_valid,
    input  logic [5*NUM_SRC-1:0]    src_cause,
    input  logic [XLEN*NUM_SRC-1:0] src_pc,
    input  logic [XLEN*NUM_SRC-1:0] src_tval,
    input  logic                    mem_valid,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [2:0]              mem_funct3,
    input  logic [XLEN-1:0]         mem_addr,
    input  logic [XLEN-1:0]         mem_pc,
    input  logic                    retire,
    input  logic                    trap_ack,
    output logic                    trap_valid,
    output logic [4:0]              trap_cause,
    output logic [XLEN-1:0]         trap_pc,
    output logic [XLEN-1:0]         trap_tval,
    output logic [3:0]              trap_src,
    output logic                    overrun,
    output logic                    lockup
);

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_LOCK} state_e;

    state_e         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           ovr_q, ovr_d;
    logic [4:0]     cause_q, cause_d;
    logic [XLEN-1:0] pc_q, pc_d, tval_q, tval_d;
    logic [3:0]     src_q, src_d;

    // Low address bits that must be zero for the access size; dword only exists on RV64.
    logic [2:0] off_mask;
    logic       mis_req;
    always_comb begin
        case (mem_funct3[1:0])
            2'b00:   off_mask = 3'b000;
            2'b01:   off_mask = 3'b001;
            2'b10:   off_mask = 3'b011;
            default: off_mask = (XLEN == 64) ? 3'b111 : 3'b000;
        endcase
    end
    assign mis_req = (MISALIGN_TRAP != 0) && mem_valid && (mem_read || mem_write)
                     && (|(mem_addr[2:0] & off_mask));

    logic            any_req;
    logic [4:0]      win_cause;
    logic [XLEN-1:0] win_pc, win_tval;
    logic [3:0]      win_src;

    // Scan youngest to oldest so the oldest valid source overwrites; misalign wins last.
    always_comb begin
        any_req   = 1'b0;
        win_cause = '0;
        win_pc    = '0;
        win_tval  = '0;
        win_src   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_valid[i]) begin
                any_req   = 1'b1;
                win_cause = src_cause[5*i +: 5];
                win_pc    = src_pc[XLEN*i +: XLEN];
                win_tval  = src_tval[XLEN*i +: XLEN];
                win_src   = 4'(i + 1);
            end
        end
        if (mis_req) begin
            any_req   = 1'b1;
            win_cause = mem_write ? 5'd6 : 5'd4;
            win_pc    = mem_pc;
            win_tval  = mem_addr;
            win_src   = 4'd0;
        end
    end

    logic [7:0] cnt_acked;
    assign cnt_acked = (retire ? 8'd0 : cnt_q) + 8'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovr_d   = ovr_q;
        cause_d = cause_q;
        pc_d    = pc_q;
        tval_d  = tval_q;
        src_d   = src_q;
        case (state_q)
            S_IDLE: begin
                if (retire) cnt_d = 8'd0;
                if (any_req) begin
                    state_d = S_PEND;
                    cause_d = win_cause;
                    pc_d    = win_pc;
                    tval_d  = win_tval;
                    src_d   = win_src;
                end
            end
            S_PEND: begin
                if (trap_ack) begin
                    // Requests in the ack cycle belong to the flushed pipeline and are dropped silently.
                    cnt_d   = cnt_acked;
                    state_d = (cnt_acked == 8'(LOCKUP_LIMIT)) ? S_LOCK : S_IDLE;
                end else begin
                    if (retire)  cnt_d = 8'd0;
                    if (any_req) ovr_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
            cause_q <= '0;
            pc_q    <= '0;
            tval_q  <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
            tval_q  <= tval_d;
            src_q   <= src_d;
        end
    end

    assign trap_valid = (state_q == S_PEND);
    assign lockup     = (state_q == S_LOCK);
    assign overrun    = ovr_q;
    assign trap_cause = cause_q;
    assign trap_pc    = pc_q;
    assign trap_tval  = tval_q;
    assign trap_src   = src_q;

    logic unused_bits;
    assign unused_bits = ^{mem_funct3[2], mem_addr[XLEN-1:3]};

endmodule

// File: tb/tb_trap_arbiter.sv
// Drives an RV64 arbiter (misalign on, limit 3) and an RV32 one (misalign off, limit 8)
// from shared stimulus and compares both against a queue-free behavioural model.
module tb_trap_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   src_valid;
    logic [19:0]  src_cause;
    logic [255:0] src_pc, src_tval;
    logic [127:0] pc32, tval32;
    logic         mem_valid, mem_read, mem_write;
    logic [2:0]   mem_funct3;
    logic [63:0]  mem_addr, mem_pc;
    logic         retire, trap_ack;

    logic a_tv, a_ovr, a_lock, b_tv, b_ovr, b_lock;
    logic [4:0]  a_cause, b_cause;
    logic [63:0] a_pc, a_tval;
    logic [31:0] b_pc, b_tval;
    logic [3:0]  a_src, b_src;

    always #5 clk = ~clk;

    always_comb begin
        pc32 = '0;
        tval32 = '0;
        for (int i = 0; i < 4; i++) begin
            pc32[32*i +: 32]   = src_pc[64*i +: 32];
            tval32[32*i +: 32] = src_tval[64*i +: 32];
        end
    end

    trap_arbiter #(.XLEN(64), .NUM_SRC(4), .MISALIGN_TRAP(1), .LOCKUP_LIMIT(3)) u_a (
        .clk(clk), .reset(reset), .src_valid(src_valid), .src_cause(src_cause),
        .src_pc(src_pc), .src_tval(src_tval), .mem_valid(mem_valid), .mem_read(mem_read),
        .mem_write(mem_write), .mem_funct3(mem_funct3), .mem_addr(mem_addr), .mem_pc(mem_pc),
        .retire(retire), .trap_ack(trap_ack), .trap_valid(a_tv), .trap_cause(a_cause),
        .trap_pc(a_pc), .trap_tval(a_tval), .trap_src(a_src), .overrun(a_ovr), .lockup(a_lock));

    trap_arbiter #(.XLEN(32), .NUM_SRC(4), .MISALIGN_TRAP(0), .LOCKUP_LIMIT(8)) u_b (
        .clk(clk), .reset(reset), .src_valid(src_valid), .src_cause(src_cause),
        .src_pc(pc32), .src_tval(tval32), .mem_valid(mem_valid), .mem_read(mem_read),
        .mem_write(mem_write), .mem_funct3(mem_funct3), .mem_addr(mem_addr[31:0]),
        .mem_pc(mem_pc[31:0]), .retire(retire), .trap_ack(trap_ack), .trap_valid(b_tv),
        .trap_cause(b_cause), .trap_pc(b_pc), .trap_tval(b_tval), .trap_src(b_src),
        .overrun(b_ovr), .lockup(b_lock));

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // Model: index 0 = RV64 instance, 1 = RV32 instance
    int          lim[2]    = '{3, 8};
    bit          mis_en[2] = '{1'b1, 1'b0};
    int          xl[2]     = '{64, 32};
    bit          m_pend[2], m_lock[2], m_ovr[2];
    int          m_cnt[2];
    logic [4:0]  m_cause[2];
    logic [63:0] m_pc[2], m_tval[2];
    logic [3:0]  m_src[2];

    function automatic logic [63:0] trunc(int m, logic [63:0] v);
        return (xl[m] == 32) ? {32'b0, v[31:0]} : v;
    endfunction

    task automatic mstep(input int m);
        bit req = 0;
        logic [4:0] c = '0;
        logic [63:0] p = '0, t = '0;
        logic [3:0] s = '0;
        int bytes;
        if (reset) begin
            m_pend[m] = 0; m_lock[m] = 0; m_ovr[m] = 0; m_cnt[m] = 0;
            m_cause[m] = '0; m_pc[m] = '0; m_tval[m] = '0; m_src[m] = '0;
            return;
        end
        if (m_lock[m]) return;
        bytes = 1 << mem_funct3[1:0];
        if (mis_en[m] && mem_valid && (mem_read || mem_write) && !(xl[m] == 32 && bytes == 8)
            && (trunc(m, mem_addr) % bytes != 0)) begin
            req = 1; c = mem_write ? 5'd6 : 5'd4;
            p = trunc(m, mem_pc); t = trunc(m, mem_addr); s = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!req && src_valid[i]) begin
                    req = 1; c = src_cause[5*i +: 5];
                    p = trunc(m, src_pc[64*i +: 64]); t = trunc(m, src_tval[64*i +: 64]);
                    s = 4'(i + 1);
                end
            end
        end
        if (m_pend[m]) begin
            if (trap_ack) begin
                m_cnt[m] = (retire ? 0 : m_cnt[m]) + 1;
                m_pend[m] = 0;
                if (m_cnt[m] == lim[m]) m_lock[m] = 1;
            end else begin
                if (retire) m_cnt[m] = 0;
                if (req) m_ovr[m] = 1;
            end
        end else begin
            if (retire) m_cnt[m] = 0;
            if (req) begin
                m_pend[m] = 1; m_cause[m] = c; m_pc[m] = p; m_tval[m] = t; m_src[m] = s;
            end
        end
    endtask

    task automatic cmp_all();
        chk("a_valid", a_tv, m_pend[0]);
        chk("a_lockup", a_lock, m_lock[0]);
        chk("a_overrun", a_ovr, m_ovr[0]);
        if (m_pend[0] || reset) begin
            chk("a_cause", a_cause, m_cause[0]);
            chk("a_pc", a_pc, m_pc[0]);
            chk("a_tval", a_tval, m_tval[0]);
            chk("a_src", a_src, m_src[0]);
        end
        chk("b_valid", b_tv, m_pend[1]);
        chk("b_lockup", b_lock, m_lock[1]);
        chk("b_overrun", b_ovr, m_ovr[1]);
        if (m_pend[1] || reset) begin
            chk("b_cause", b_cause, m_cause[1]);
            chk("b_pc", {32'b0, b_pc}, m_pc[1]);
            chk("b_tval", {32'b0, b_tval}, m_tval[1]);
            chk("b_src", b_src, m_src[1]);
        end
    endtask

    // One clock: inputs already driven, model follows the edge, outputs sampled 1ns later.
    task automatic cyc();
        @(posedge clk);
        mstep(0);
        mstep(1);
        #1;
        cmp_all();
    endtask

    task automatic idle();
        reset = 0; src_valid = '0; mem_valid = 0; mem_read = 0; mem_write = 0;
        mem_funct3 = '0; mem_addr = '0; mem_pc = '0; retire = 0; trap_ack = 0;
    endtask

    task automatic ack();
        idle(); trap_ack = 1; cyc(); idle();
    endtask

    task automatic do_reset();
        idle(); reset = 1; cyc(); reset = 0;
    endtask

    task automatic trap_src0();
        idle(); src_valid = 4'b0001; cyc(); ack();
    endtask

    initial begin
        src_cause = {5'd11, 5'd2, 5'd13, 5'd1};
        for (int i = 0; i < 4; i++) begin
            src_pc[64*i +: 64]   = 64'h8000_0000_0000_1000 + 64'(i * 16);
            src_tval[64*i +: 64] = 64'hdead_0000_0000_0100 + 64'(i);
        end
        do_reset();
        chk("rst_a_valid", a_tv, 0);
        chk("rst_a_src", a_src, 0);
        chk("rst_b_lockup", b_lock, 0);

        // priority: misalign beats sources on A; source 1 wins on B
        idle(); mem_valid = 1; mem_read = 1; mem_funct3 = 3'b010;
        mem_addr = 64'h1002; mem_pc = 64'h400; src_valid = 4'b0110;
        cyc();
        chk("prio_valid", a_tv, 1);
        chk("prio_cause", a_cause, 4);
        chk("prio_tval", a_tval, 64'h1002);
        chk("prio_src", a_src, 0);
        chk("prio_b_src", b_src, 2);
        ack();
        src_valid = 4'b0110; cyc();
        chk("prio2_src", a_src, 2);
        ack();
        retire = 1; cyc(); idle();

        // misalign disabled on B, RV64 dword alignment on A
        mem_valid = 1; mem_write = 1; mem_funct3 = 3'b010; mem_addr = 64'h3; cyc();
        chk("nomis_b", b_tv, 0);
        chk("sw_cause", a_cause, 6);
        ack(); retire = 1; cyc(); idle();
        mem_valid = 1; mem_write = 1; mem_funct3 = 3'b011; mem_addr = 64'h8; cyc();
        chk("sd_aligned", a_tv, 0);
        mem_addr = 64'hC; cyc();
        chk("sd_mis_valid", a_tv, 1);
        chk("sd_mis_cause", a_cause, 6);
        chk("sd_mis_tval", a_tval, 64'hC);
        ack(); retire = 1; cyc(); idle();

        // handshake: ack with new request present drops it silently
        src_valid = 4'b0100; cyc(); idle();
        for (int k = 0; k < 3; k++) begin cyc(); chk("hs_hold", a_tv, 1); end
        trap_ack = 1; src_valid = 4'b0001; cyc();
        chk("hs_release", a_tv, 0);
        chk("hs_no_ovr", a_ovr, 0);
        idle(); src_valid = 4'b0001; cyc();
        chk("hs_recapture", a_tv, 1);
        chk("hs_src", a_src, 1);
        ack(); retire = 1; cyc(); idle();

        // overrun
        src_valid = 4'b0010; cyc();
        src_valid = 4'b0001; cyc();
        chk("ovr_set", a_ovr, 1);
        chk("ovr_keep_src", a_src, 2);
        ack();

        // lockup at limit 3
        do_reset();
        for (int k = 0; k < 3; k++) trap_src0();
        chk("lock_set", a_lock, 1);
        chk("lock_no_valid", a_tv, 0);
        src_valid = 4'b0001; cyc();
        chk("lock_ignore", a_tv, 0);
        do_reset();
        chk("lock_rst", a_lock, 0);
        chk("lock_rst_src", a_src, 0);

        // retire coinciding with ack counts as 1
        trap_src0(); trap_src0();
        idle(); src_valid = 4'b0001; cyc();
        idle(); trap_ack = 1; retire = 1; cyc(); idle();
        chk("coinc_nolock", a_lock, 0);
        trap_src0();
        chk("coinc_nolock2", a_lock, 0);
        trap_src0();
        chk("coinc_lock", a_lock, 1);
        do_reset();

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            reset      = (m_lock[0] && ($urandom % 4 == 0)) || ($urandom % 200 == 0);
            src_valid  = ($urandom % 3 == 0) ? 4'($urandom) : 4'b0;
            src_cause  = 20'($urandom);
            for (int i = 0; i < 4; i++) begin
                src_pc[64*i +: 64]   = {$urandom, $urandom};
                src_tval[64*i +: 64] = {$urandom, $urandom};
            end
            mem_valid  = ($urandom % 2 == 0);
            mem_read   = ($urandom % 2 == 0);
            mem_write  = ($urandom % 3 == 0);
            mem_funct3 = 3'($urandom);
            mem_addr   = {$urandom, $urandom};
            mem_pc     = {$urandom, $urandom};
            retire     = ($urandom % 5 == 0);
            trap_ack   = ($urandom % 3 == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
